disp_arbiter: RTL and testbench
===============================

DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000: minimum cycles requester 1 keeps the display before requester 0 can preempt it; legal range 1..65535.
REQ-002 Parameter BLINK_W, default 24: blink counter width; blank toggles every 2^(BLINK_W-1) cycles; legal range 2..32.
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req0  in  1  display request from requester 0 (high priority, e.g. status message); level-held while the display is wanted.
REQ-006 val0  in  16  requester 0 digits: [15:12] leftmost, [3:0] rightmost.
REQ-007 blink0  in  1  requester 0 wants its digits blinked.
REQ-008 req1  in  1  display request from requester 1 (low priority, e.g. score); level-held.
REQ-009 val1  in  16  requester 1 digits, same packing as val0.
REQ-010 gnt0, gnt1  out  1 each  grant flags; at most one is high in any cycle.
REQ-011 A, B, C, D  out  4 each  registered digit values for the 4-digit multiplexer; A = val[15:12] through D = val[3:0].
REQ-012 blank  out  1  high = downstream forces all anodes off.

Function
REQ-013 FSM states: IDLE, GRANT0, GRANT1; state, grants, digits and blank are all registered.
REQ-014 IDLE: req0=1 -> GRANT0; else req1=1 -> GRANT1; else stay. Simultaneous req0 and req1 -> GRANT0.
REQ-015 GRANT0: req0=0 and req1=1 -> GRANT1; req0=0 and req1=0 -> IDLE; else stay. GRANT0 is never preempted.
REQ-016 GRANT1, checked in this order:
  - req1=0 and req0=1 -> GRANT0.
  - req1=0 and req0=0 -> IDLE.
  - req0=1 and hold_cnt = HOLD_CYCLES-1 -> GRANT0 (preempt).
  - else stay.
REQ-017 hold_cnt, 16 bits:
  - cleared on every edge that enters GRANT1;
  - increments by 1 each cycle in GRANT1;
  - saturates at HOLD_CYCLES-1.
REQ-018 gnt0 = 1 exactly when state = GRANT0; gnt1 = 1 exactly when state = GRANT1. Grants appear on the edge the state is entered.
REQ-019 Digit loading:
  - on every edge whose next state is GRANTn, {A,B,C,D} <= valn, so digits track valn with one-cycle latency;
  - on an edge whose next state is IDLE, {A,B,C,D} <= 0.
REQ-020 blink_cnt, BLINK_W bits:
  - cleared on the edge that enters GRANT0;
  - increments each cycle in GRANT0 and wraps modulo 2^BLINK_W.
REQ-021 blank, registered, takes the value on each edge:
  - next state IDLE: 1;
  - next state GRANT1: 0;
  - next state GRANT0, entry edge: 0;
  - next state GRANT0, staying: blink0 & blink_cnt[BLINK_W-1] (counter value after the increment).
REQ-022 Requester handshake: a requester treats its digits as displayed once its gnt is high; dropping req releases the display on the next edge.

Reset
REQ-023 rst=1 forces, immediately and independent of clk:
  - state = IDLE;
  - gnt0 = gnt1 = 0;
  - A = B = C = D = 0;
  - blank = 1;
  - hold_cnt = blink_cnt = 0.
REQ-024 rst asserted mid-grant aborts the grant immediately. After rst deasserts, the first rising edge evaluates IDLE transitions normally.

Verification (bench uses HOLD_CYCLES=4, BLINK_W=3)
REQ-025 Reset: drive rst=1 with req0=1 -> gnt0=0, gnt1=0, blank=1, A..D=0. Release rst -> gnt0=1 on the first edge.
REQ-026 Simultaneous request: req0=req1=1, val0=16'h1234, val1=16'hABCD from IDLE -> one edge later gnt0=1, A=1, B=2, C=3, D=4, blank=0. Drop req0 -> next edge gnt1=1, A..D = A,B,C,D.
REQ-027 Preemption: hold req1 in GRANT1; raise req0 on the 2nd cycle of the grant -> gnt1 stays high until hold_cnt reaches 3, then gnt0=1 on the following edge. gnt0 and gnt1 are never high together.
REQ-028 Blink: GRANT0 with blink0=1 -> blank reads 0,0,0,0 in the first 4 cycles after entry, then 1,1,1,1, then repeats. Setting blink0=0 -> blank=0 on the next edge.
REQ-029 Live update: in GRANT1 change val1 from 16'h0000 to 16'h0909 -> A..D = 0,9,0,9 exactly one edge later.
REQ-030 Release: drop req0 with req1=0 -> next edge IDLE, gnt0=0, blank=1, A..D=0.

Source files
------------

// File: rtl/disp_arbiter.sv
// Two-requester display arbiter for a 4-digit multiplexed display.
// Requester 0 has priority; requester 1 is preempted once it has held the display HOLD_CYCLES.
module disp_arbiter #(
    parameter int HOLD_CYCLES = 1000,
    parameter int BLINK_W     = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] val0,
    input  logic        blink0,
    input  logic        req1,
    input  logic [15:0] val1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [3:0]  A,
    output logic [3:0]  B,
    output logic [3:0]  C,
    output logic [3:0]  D,
    output logic        blank
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT0, S_GRANT1} state_t;

    localparam logic [15:0] HOLD_MAX = 16'(HOLD_CYCLES - 1);

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_hold_cnt;
    logic [BLINK_W-1:0]  r_blink_cnt;
    logic [BLINK_W-1:0]  w_blink_inc;

    assign w_blink_inc = r_blink_cnt + BLINK_W'(1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_GRANT0: begin
                if (req0)      w_next = S_GRANT0;
                else if (req1) w_next = S_GRANT1;
                else           w_next = S_IDLE;
            end
            S_GRANT1: begin
                if (!req1)                            w_next = req0 ? S_GRANT0 : S_IDLE;
                else if (req0 && r_hold_cnt == HOLD_MAX) w_next = S_GRANT0;
                else                                  w_next = S_GRANT1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            {A, B, C, D} <= 16'h0000;
            blank       <= 1'b1;
            r_hold_cnt  <= 16'h0000;
            r_blink_cnt <= '0;
        end else begin
            r_state <= w_next;
            gnt0    <= (w_next == S_GRANT0);
            gnt1    <= (w_next == S_GRANT1);
            case (w_next)
                S_GRANT0: begin
                    {A, B, C, D} <= val0;
                    // Blink phase restarts on every fresh grant so the message shows first.
                    if (r_state != S_GRANT0) begin
                        r_blink_cnt <= '0;
                        blank       <= 1'b0;
                    end else begin
                        r_blink_cnt <= w_blink_inc;
                        blank       <= blink0 & w_blink_inc[BLINK_W-1];
                    end
                end
                S_GRANT1: begin
                    {A, B, C, D} <= val1;
                    blank        <= 1'b0;
                    if (r_state != S_GRANT1)      r_hold_cnt <= 16'h0000;
                    else if (r_hold_cnt != HOLD_MAX) r_hold_cnt <= r_hold_cnt + 16'h0001;
                end
                default: begin
                    {A, B, C, D} <= 16'h0000;
                    blank        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_arbiter.sv
// Bench for disp_arbiter: directed vector table, async reset sequence, and a
// randomized run against an ownership/elapsed-time reference model.
module tb_disp_arbiter;

    localparam int HOLD = 4;
    localparam int BW   = 3;
    localparam int BP   = 1 << BW;

    logic        clk = 1'b0;
    logic        rst, req0, blink0, req1;
    logic [15:0] val0, val1;
    logic        gnt0, gnt1, blank;
    logic [3:0]  A, B, C, D;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    disp_arbiter #(.HOLD_CYCLES(HOLD), .BLINK_W(BW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .val0(val0), .blink0(blink0),
        .req1(req1), .val1(val1),
        .gnt0(gnt0), .gnt1(gnt1),
        .A(A), .B(B), .C(C), .D(D),
        .blank(blank)
    );

    typedef struct {
        logic        rst, req0, blink0, req1;
        logic [15:0] val0, val1;
        logic        g0, g1, blank;
        logic [15:0] dig;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic q0, logic [15:0] v0, logic b0, logic q1,
                                logic [15:0] v1, logic g0, logic g1, logic [15:0] dg, logic bl);
        vec_t v;
        v.rst = r; v.req0 = q0; v.val0 = v0; v.blink0 = b0; v.req1 = q1; v.val1 = v1;
        v.g0 = g0; v.g1 = g1; v.dig = dg; v.blank = bl;
        return v;
    endfunction

    task automatic chk(string name, logic [18:0] act, logic [18:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got g0g1/dig/blank=%h required %h", name, act, exp);
    endtask

    function automatic logic [18:0] outs();
        return {gnt0, gnt1, A, B, C, D, blank};
    endfunction

    // Reference model: who owns the display and how long they have had it.
    int own, t0, t1;
    logic [18:0] exp_o;

    task automatic model_step();
        int nxt;
        logic eb;
        logic [15:0] ed;
        if (own == 1) begin
            if (!req1)                      nxt = req0 ? 0 : -1;
            else if (req0 && t1 >= HOLD-1)  nxt = 0;
            else                            nxt = 1;
        end else begin
            nxt = req0 ? 0 : (req1 ? 1 : -1);
        end
        if (nxt == 0) begin
            if (own != 0) begin t0 = 0; eb = 1'b0; end
            else begin t0++; eb = blink0 && ((t0 % BP) >= BP/2); end
            ed = val0;
        end else if (nxt == 1) begin
            t1 = (own != 1) ? 0 : t1 + 1;
            eb = 1'b0;
            ed = val1;
        end else begin
            eb = 1'b1;
            ed = 16'h0000;
        end
        own   = nxt;
        exp_o = {nxt == 0, nxt == 1, ed, eb};
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b1; blink0 = 1'b0; req1 = 1'b0; val0 = 16'h1234; val1 = 16'h0000;
        #2;
        chk("reset_state", outs(), {1'b0, 1'b0, 16'h0000, 1'b1});

        tbl.push_back(mk(1, 1, 16'h1234, 0, 0, 16'h0000, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 1, 16'h1234, 0, 1, 16'hABCD, 1, 0, 16'h1234, 0));
        tbl.push_back(mk(0, 0, 16'h1234, 0, 1, 16'hABCD, 0, 1, 16'hABCD, 0));
        tbl.push_back(mk(0, 0, 16'h1234, 0, 1, 16'h0000, 0, 1, 16'h0000, 0));
        tbl.push_back(mk(0, 1, 16'h5555, 0, 1, 16'h0909, 0, 1, 16'h0909, 0));
        tbl.push_back(mk(0, 1, 16'h5555, 0, 1, 16'h0909, 0, 1, 16'h0909, 0));
        tbl.push_back(mk(0, 1, 16'h5555, 1, 1, 16'h0909, 1, 0, 16'h5555, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 16'h5555, 1, 1, 16'h0909, 1, 0, 16'h5555, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 16'h5555, 1, 1, 16'h0909, 1, 0, 16'h5555, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 16'h5555, 1, 0, 16'h0909, 1, 0, 16'h5555, 0));
        tbl.push_back(mk(0, 1, 16'h5555, 1, 0, 16'h0909, 1, 0, 16'h5555, 1));
        tbl.push_back(mk(0, 1, 16'h5555, 0, 0, 16'h0909, 1, 0, 16'h5555, 0));
        tbl.push_back(mk(0, 0, 16'h5555, 0, 0, 16'h0909, 0, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 0, 16'h5555, 0, 0, 16'h0909, 0, 0, 16'h0000, 1));

        @(negedge clk);
        foreach (tbl[i]) begin
            rst = tbl[i].rst; req0 = tbl[i].req0; val0 = tbl[i].val0; blink0 = tbl[i].blink0;
            req1 = tbl[i].req1; val1 = tbl[i].val1;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(), {tbl[i].g0, tbl[i].g1, tbl[i].dig, tbl[i].blank});
        end

        // Asynchronous reset in the middle of a grant, then normal restart.
        req0 = 1'b1; val0 = 16'h7777; req1 = 1'b0; blink0 = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("pre_async_grant", outs(), {1'b1, 1'b0, 16'h7777, 1'b0});
        #2 rst = 1'b1;
        #1 chk("async_reset", outs(), {1'b0, 1'b0, 16'h0000, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("post_reset_grant", outs(), {1'b1, 1'b0, 16'h7777, 1'b0});

        // Randomized run from a clean reset.
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; blink0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        own = -1; t0 = 0; t1 = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 5) == 0) req0 = ~req0;
            if ($urandom_range(0, 6) == 0) req1 = ~req1;
            if ($urandom_range(0, 4) == 0) blink0 = ~blink0;
            if ($urandom_range(0, 2) == 0) val0 = 16'($urandom);
            if ($urandom_range(0, 2) == 0) val1 = 16'($urandom);
            model_step();
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("rand%0d", cyc), outs(), exp_o);
            chk($sformatf("excl%0d", cyc), {18'h0, gnt0 & gnt1}, 19'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
